// File: rtl/seg7_scan_ctrl.sv
// Eight-digit seven-segment scan controller: blanks, then drives, one digit at
// a time; new display words are staged in a shadow register and committed only
// at the frame boundary, so a single frame never mixes old and new digits.
module seg7_scan_ctrl #(
    parameter int unsigned DIV_CYCLES   = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic [7:0]  load_mask,
    output logic        load_ready,
    output logic        frame_tick,
    output logic [2:0]  digit_idx,
    output logic        an0,
    output logic        an1,
    output logic        an2,
    output logic        an3,
    output logic        an4,
    output logic        an5,
    output logic        an6,
    output logic        an7,
    output logic        segA,
    output logic        segB,
    output logic        segC,
    output logic        segD,
    output logic        segE,
    output logic        segF,
    output logic        segG
);

    localparam int unsigned CNT_MAX = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Display payload: eight hex nibbles plus per-digit enable.
    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  mask;
    } disp_t;

    state_e             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    disp_t              active_q, active_d;
    disp_t              shadow_q, shadow_d;
    logic               pending_q, pending_d;

    logic               load_ready_q, load_ready_d;
    logic               frame_tick_q, frame_tick_d;
    logic [7:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;

    logic               at_boundary;
    logic [3:0]         nibble;

    // Active-low hex decode, bit 6 = A down to bit 0 = G.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'b1111111;
        case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State, data and output registers; reset leaves the display dark.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            frame_tick_q <= 1'b0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    // Next-state sequencing, handshake, commit, and pin values for the next cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + CNT_W'(1);
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        an_d         = 8'hFF;
        seg_d        = 7'h7F;
        nibble       = 4'h0;

        at_boundary  = (state_q == ST_DRIVE) && (idx_q == 3'd7) && (cnt_q == DIV_LAST);

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Commit and accept are exclusive: ready is low whenever a word is pending.
        if (at_boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (load_valid && load_ready_q) begin
            shadow_d.word = load_data;
            shadow_d.mask = load_mask;
            pending_d     = 1'b1;
        end

        // Pins are computed from next state so they line up with the state on the pins.
        nibble = active_d.word[{idx_d, 2'b00} +: 4];
        if (state_d == ST_DRIVE) begin
            an_d[idx_d] = ~active_d.mask[idx_d];
            if (active_d.mask[idx_d]) begin
                seg_d = hex_to_seg(nibble);
            end
        end

        load_ready_d = ~pending_d;
        frame_tick_d = (state_d == ST_DRIVE) && (idx_d == 3'd7) && (cnt_d == DIV_LAST);
    end

    assign load_ready = load_ready_q;
    assign frame_tick = frame_tick_q;
    assign digit_idx  = idx_q;

    assign an0  = an_q[0];
    assign an1  = an_q[1];
    assign an2  = an_q[2];
    assign an3  = an_q[3];
    assign an4  = an_q[4];
    assign an5  = an_q[5];
    assign an6  = an_q[6];
    assign an7  = an_q[7];

    assign segA = seg_q[6];
    assign segB = seg_q[5];
    assign segC = seg_q[4];
    assign segD = seg_q[3];
    assign segE = seg_q[2];
    assign segF = seg_q[1];
    assign segG = seg_q[0];

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIV_CYCLES=4, BLANK_CYCLES=2 (48-clock frame).
module tb_seg7_scan_ctrl;

    localparam int unsigned DIV   = 4;
    localparam int unsigned BLK   = 2;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic [31:0] load_data;
    logic [7:0]  load_mask;
    logic        load_ready;
    logic        frame_tick;
    logic [2:0]  digit_idx;
    logic        an0, an1, an2, an3, an4, an5, an6, an7;
    logic        segA, segB, segC, segD, segE, segF, segG;

    logic [7:0]  an_bus;
    logic [6:0]  seg_bus;

    int cyc;
    int checks;
    int errors;

    assign an_bus  = {an7, an6, an5, an4, an3, an2, an1, an0};
    assign seg_bus = {segA, segB, segC, segD, segE, segF, segG};

    seg7_scan_ctrl #(
        .DIV_CYCLES   (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_mask  (load_mask),
        .load_ready (load_ready),
        .frame_tick (frame_tick),
        .digit_idx  (digit_idx),
        .an0        (an0),
        .an1        (an1),
        .an2        (an2),
        .an3        (an3),
        .an4        (an4),
        .an5        (an5),
        .an6        (an6),
        .an7        (an7),
        .segA       (segA),
        .segB       (segB),
        .segC       (segC),
        .segD       (segD),
        .segE       (segE),
        .segF       (segF),
        .segG       (segG)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-entered decode table (A..G, active-low).
    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] r;
        r = 7'b1111111;
        case (v)
            4'h0: r = 7'b0000001;
            4'h1: r = 7'b1001111;
            4'h2: r = 7'b0010010;
            4'h3: r = 7'b0000110;
            4'h4: r = 7'b1001100;
            4'h5: r = 7'b0100100;
            4'h6: r = 7'b0100000;
            4'h7: r = 7'b0001111;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0000100;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b1100000;
            4'hC: r = 7'b0110001;
            4'hD: r = 7'b1000010;
            4'hE: r = 7'b0110000;
            4'hF: r = 7'b0111000;
            default: r = 7'b1111111;
        endcase
        return r;
    endfunction

    // Advance one clock; cycle c is sampled at the falling edge after c rising edges.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Hold reset low for three clocks, release on a falling edge; that cycle is cycle 0.
    task automatic do_reset();
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_mask  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_idx;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_mask  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (an_bus !== 8'hFF || seg_bus !== 7'h7F) begin
            errors++;
            $display("FAIL reset_dark an=%h seg=%b exp an=ff seg=1111111", an_bus, seg_bus);
        end
        checks++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b0 || digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_ctrl ready=%b tick=%b idx=%0d exp 1 0 0", load_ready, frame_tick, digit_idx);
        end
        reset = 1'b1;
        cyc   = 0;
        for (int c = 0; c <= 48; c++) begin
            run_to(c);
            exp_idx = 3'((c % 48) / 6);
            checks++;
            if (an_bus !== 8'hFF || seg_bus !== 7'h7F) begin
                errors++;
                $display("FAIL first_frame_dark cyc=%0d an=%h seg=%b exp an=ff seg=1111111", cyc, an_bus, seg_bus);
            end
            checks++;
            if (frame_tick !== (c == 47)) begin
                errors++;
                $display("FAIL first_frame_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, (c == 47));
            end
            checks++;
            if (digit_idx !== exp_idx) begin
                errors++;
                $display("FAIL first_frame_idx cyc=%0d got=%0d exp=%0d", cyc, digit_idx, exp_idx);
            end
            checks++;
            if (load_ready !== 1'b1) begin
                errors++;
                $display("FAIL first_frame_ready cyc=%0d got=%b exp=1", cyc, load_ready);
            end
        end
    endtask

    task automatic test_load_commit();
        logic [31:0] word;
        logic [7:0]  exp_an;
        logic [6:0]  exp_sg;
        int          d;
        int          ph;
        word = 32'h76543210;
        do_reset();
        run_to(5);
        load_valid = 1'b1;
        load_data  = word;
        load_mask  = 8'hFF;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_ready_fall cyc=%0d got=%b exp=0", cyc, load_ready);
        end
        run_to(46);
        checks++;
        if (an_bus !== 8'hFF) begin
            errors++;
            $display("FAIL commit_not_early cyc=%0d an=%h exp=ff", cyc, an_bus);
        end
        run_to(47);
        checks++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL commit_boundary cyc=%0d tick=%b ready=%b exp tick=1 ready=0", cyc, frame_tick, load_ready);
        end
        run_to(48);
        checks++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL commit_ready_rise cyc=%0d ready=%b tick=%b exp ready=1 tick=0", cyc, load_ready, frame_tick);
        end
        for (int c = 48; c < 96; c++) begin
            run_to(c);
            d  = (c - 48) / 6;
            ph = (c - 48) % 6;
            exp_an = 8'hFF;
            exp_sg = 7'h7F;
            if (ph >= 2) begin
                exp_an = ~(8'h01 << d);
                exp_sg = hex_seg(word[4*d +: 4]);
            end
            checks++;
            if (an_bus !== exp_an || seg_bus !== exp_sg) begin
                errors++;
                $display("FAIL commit_frame cyc=%0d an=%h seg=%b exp an=%h seg=%b", cyc, an_bus, seg_bus, exp_an, exp_sg);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_valid = 1'b1;
        load_data  = 32'h11111111;
        load_mask  = 8'hFF;
        tick();
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first_accept cyc=%0d ready=%b exp=0", cyc, load_ready);
        end
        load_data = 32'h22222222;
        run_to(47);
        checks++;
        if (load_ready !== 1'b0 || frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL b2b_held cyc=%0d ready=%b tick=%b exp ready=0 tick=1", cyc, load_ready, frame_tick);
        end
        run_to(48);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_commit cyc=%0d ready=%b exp=1", cyc, load_ready);
        end
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_accept cyc=%0d ready=%b exp=0", cyc, load_ready);
        end
        run_to(50);
        checks++;
        if (an_bus !== 8'hFE || seg_bus !== 7'b1001111) begin
            errors++;
            $display("FAIL b2b_first_word cyc=%0d an=%h seg=%b exp an=fe seg=1001111", cyc, an_bus, seg_bus);
        end
        run_to(92);
        checks++;
        if (an_bus !== 8'h7F || seg_bus !== 7'b1001111) begin
            errors++;
            $display("FAIL b2b_first_word_d7 cyc=%0d an=%h seg=%b exp an=7f seg=1001111", cyc, an_bus, seg_bus);
        end
        run_to(95);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_pending_held cyc=%0d ready=%b exp=0", cyc, load_ready);
        end
        run_to(96);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_commit cyc=%0d ready=%b exp=1", cyc, load_ready);
        end
        run_to(98);
        checks++;
        if (an_bus !== 8'hFE || seg_bus !== 7'b0010010) begin
            errors++;
            $display("FAIL b2b_second_word cyc=%0d an=%h seg=%b exp an=fe seg=0010010", cyc, an_bus, seg_bus);
        end
        run_to(128);
        checks++;
        if (an_bus !== 8'hDF || seg_bus !== 7'b0010010) begin
            errors++;
            $display("FAIL b2b_second_word_d5 cyc=%0d an=%h seg=%b exp an=df seg=0010010", cyc, an_bus, seg_bus);
        end
    endtask

    task automatic test_boundary_collision();
        do_reset();
        run_to(5);
        load_valid = 1'b1;
        load_data  = 32'h33333333;
        load_mask  = 8'hFF;
        tick();
        load_valid = 1'b0;
        run_to(95);
        checks++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_setup cyc=%0d tick=%b ready=%b exp tick=1 ready=1", cyc, frame_tick, load_ready);
        end
        load_valid = 1'b1;
        load_data  = 32'h44444444;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_accept cyc=%0d ready=%b exp=0", cyc, load_ready);
        end
        run_to(98);
        checks++;
        if (an_bus !== 8'hFE || seg_bus !== 7'b0000110) begin
            errors++;
            $display("FAIL coll_old_word cyc=%0d an=%h seg=%b exp an=fe seg=0000110", cyc, an_bus, seg_bus);
        end
        run_to(143);
        checks++;
        if (frame_tick !== 1'b1 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL coll_boundary cyc=%0d tick=%b ready=%b exp tick=1 ready=0", cyc, frame_tick, load_ready);
        end
        run_to(144);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL coll_ready cyc=%0d ready=%b exp=1", cyc, load_ready);
        end
        run_to(146);
        checks++;
        if (an_bus !== 8'hFE || seg_bus !== 7'b1001100) begin
            errors++;
            $display("FAIL coll_new_word cyc=%0d an=%h seg=%b exp an=fe seg=1001100", cyc, an_bus, seg_bus);
        end
    endtask

    task automatic test_mask_sweep();
        logic [6:0] lit [4];
        logic [7:0] exp_an;
        logic [6:0] exp_sg;
        int         d;
        int         ph;
        lit[0] = 7'b0000000;
        lit[1] = 7'b0000100;
        lit[2] = 7'b0001000;
        lit[3] = 7'b1100000;
        do_reset();
        run_to(5);
        load_valid = 1'b1;
        load_data  = 32'hFEDCBA98;
        load_mask  = 8'h0F;
        tick();
        load_valid = 1'b0;
        for (int c = 48; c < 96; c++) begin
            run_to(c);
            d  = (c - 48) / 6;
            ph = (c - 48) % 6;
            exp_an = 8'hFF;
            exp_sg = 7'h7F;
            if (ph >= 2 && d < 4) begin
                exp_an = ~(8'h01 << d);
                exp_sg = lit[d];
            end
            checks++;
            if (an_bus !== exp_an || seg_bus !== exp_sg) begin
                errors++;
                $display("FAIL mask_sweep cyc=%0d an=%h seg=%b exp an=%h seg=%b", cyc, an_bus, seg_bus, exp_an, exp_sg);
            end
        end
    endtask

    // Runs on from the mask sweep: digit 1 of the next frame is lit when reset hits.
    task automatic test_reset_mid_drive();
        run_to(100);
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_ready_before cyc=%0d ready=%b exp=1", cyc, load_ready);
        end
        load_valid = 1'b1;
        load_data  = 32'h55555555;
        load_mask  = 8'hFF;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_pending cyc=%0d ready=%b exp=0", cyc, load_ready);
        end
        run_to(104);
        checks++;
        if (an_bus !== 8'hFD || seg_bus !== 7'b0000100) begin
            errors++;
            $display("FAIL rmid_lit cyc=%0d an=%h seg=%b exp an=fd seg=0000100", cyc, an_bus, seg_bus);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (an_bus !== 8'hFF || seg_bus !== 7'h7F) begin
            errors++;
            $display("FAIL rmid_async_dark an=%h seg=%b exp an=ff seg=1111111", an_bus, seg_bus);
        end
        checks++;
        if (load_ready !== 1'b1 || frame_tick !== 1'b0 || digit_idx !== 3'd0) begin
            errors++;
            $display("FAIL rmid_async_ctrl ready=%b tick=%b idx=%0d exp 1 0 0", load_ready, frame_tick, digit_idx);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
        for (int c = 0; c < 96; c++) begin
            run_to(c);
            checks++;
            if (an_bus !== 8'hFF || seg_bus !== 7'h7F || load_ready !== 1'b1) begin
                errors++;
                $display("FAIL rmid_stays_dark cyc=%0d an=%h seg=%b ready=%b exp an=ff seg=1111111 ready=1",
                         cyc, an_bus, seg_bus, load_ready);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_mask  = '0;
        test_reset();
        test_load_commit();
        test_back_to_back();
        test_boundary_collision();
        test_mask_sweep();
        test_reset_mid_drive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
